nps_outmem: RTL

- Stream-capture memory: the sink end of the vo/fo/datao sample stream produced by the input-memory block.
- After it is armed, it writes each valid sample into an internal RAM, and the end-of-frame strobe closes the frame.
- The CPU then reads the captured frame back through a registered read port.
- Sits at the output of an NPS processing chain, mirroring the CPU-loaded input memory at the head of the chain.

---
 rtl/nps_outmem.sv | 110 +++++++++++
 1 files changed

// File: rtl/nps_outmem.sv
// nps_outmem: stream-capture memory at the tail of an NPS chain.
// Once armed by start, valid samples (vi/datai) are written into an internal
// RAM until the end-of-frame strobe (fi) closes the frame. The CPU reads the
// captured frame back through a registered, one-cycle-latency read port.
module nps_outmem #(
   parameter int DATA_WIDTH = 16,
   parameter int DATA_NUM   = 30,
   parameter int ADR_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset_x,
   input  logic                  start,
   input  logic                  vi,
   input  logic                  fi,
   input  logic [DATA_WIDTH-1:0] datai,
   output logic                  busy,
   output logic                  done,
   output logic                  irq,
   output logic                  ovf,
   output logic [ADR_WIDTH:0]    count,
   input  logic [ADR_WIDTH-1:0]  cpu_adr,
   input  logic                  cpu_rd,
   output logic [DATA_WIDTH-1:0] cpu_rdata
);

   localparam logic [ADR_WIDTH:0] CNT_MAX = (ADR_WIDTH+1)'(DATA_NUM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] mem [DATA_NUM];
   logic [ADR_WIDTH:0]    count_q;
   logic                  ovf_q;
   logic                  irq_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  take;
   logic                  wr_en;
   logic                  drop;
   logic                  adr_ok;

   // A sample is considered only while capturing and not being restarted
   // (start wins over vi); the reset term keeps a write out of the reset cycle.
   assign take   = reset_x && (state_q == S_CAPTURE) && !start && vi;
   assign wr_en  = take && (count_q <  CNT_MAX);
   assign drop   = take && (count_q == CNT_MAX);
   assign adr_ok = ({1'b0, cpu_adr} < CNT_MAX);

   // State register
   always_ff @(posedge clk) begin
      if (!reset_x) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic: start arms/restarts from any state, fi closes a capture
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_CAPTURE;
         S_CAPTURE: if (!start && fi) state_d = S_DONE;
         S_DONE:    if (start) state_d = S_CAPTURE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state plus the registered status
   always_comb begin
      busy      = (state_q == S_CAPTURE);
      done      = (state_q == S_DONE);
      irq       = irq_q;
      ovf       = ovf_q;
      count     = count_q;
      cpu_rdata = rdata_q;
   end

   // Frame status: sample counter (saturating), sticky overflow, entry pulse
   always_ff @(posedge clk) begin
      if (!reset_x) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         irq_q <= (state_q == S_CAPTURE) && (state_d == S_DONE);
         if (start) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
         end else if (wr_en) begin
            count_q <= count_q + 1'b1;
         end else if (drop) begin
            ovf_q   <= 1'b1;
         end
      end
   end

   // Capture RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[count_q[ADR_WIDTH-1:0]] <= datai;
   end

   // Registered CPU read; a same-cycle write to the address returns old data
   always_ff @(posedge clk) begin
      if (!reset_x)    rdata_q <= '0;
      else if (cpu_rd) rdata_q <= adr_ok ? mem[cpu_adr] : '0;
   end

endmodule
